// File: rtl/acc_demux.sv
`default_nettype none
// ============================================================================
// Module   : acc_demux
// Purpose  : 1-to-NumAcc accelerator-bus demultiplexer. Requests are steered
//            by address; responses are merged round-robin into a registered
//            upstream channel; unmapped requests get a local error response.
// Revision : 1.0 - initial release
// ============================================================================
module acc_demux #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned IdWidth   = 5,
  parameter int unsigned NumAcc    = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  // upstream request
  input  logic [AddrWidth-1:0]           s_q_addr_i,
  input  logic [31:0]                    s_q_data_op_i,
  input  logic [DataWidth-1:0]           s_q_data_arga_i,
  input  logic [DataWidth-1:0]           s_q_data_argb_i,
  input  logic [DataWidth-1:0]           s_q_data_argc_i,
  input  logic [IdWidth-1:0]             s_q_id_i,
  input  logic                           s_q_valid_i,
  output logic                           s_q_ready_o,
  // upstream response
  output logic [DataWidth-1:0]           s_p_data0_o,
  output logic [DataWidth-1:0]           s_p_data1_o,
  output logic                           s_p_dual_writeback_o,
  output logic                           s_p_error_o,
  output logic [IdWidth-1:0]             s_p_id_o,
  output logic                           s_p_valid_o,
  input  logic                           s_p_ready_i,
  // downstream requests, one packed slice per accelerator
  output logic [NumAcc*AddrWidth-1:0]    m_q_addr_o,
  output logic [NumAcc*32-1:0]           m_q_data_op_o,
  output logic [NumAcc*DataWidth-1:0]    m_q_data_arga_o,
  output logic [NumAcc*DataWidth-1:0]    m_q_data_argb_o,
  output logic [NumAcc*DataWidth-1:0]    m_q_data_argc_o,
  output logic [NumAcc*IdWidth-1:0]      m_q_id_o,
  output logic [NumAcc-1:0]              m_q_valid_o,
  input  logic [NumAcc-1:0]              m_q_ready_i,
  // downstream responses
  input  logic [NumAcc*DataWidth-1:0]    m_p_data0_i,
  input  logic [NumAcc*DataWidth-1:0]    m_p_data1_i,
  input  logic [NumAcc-1:0]              m_p_dual_writeback_i,
  input  logic [NumAcc-1:0]              m_p_error_i,
  input  logic [NumAcc*IdWidth-1:0]      m_p_id_i,
  input  logic [NumAcc-1:0]              m_p_valid_i,
  output logic [NumAcc-1:0]              m_p_ready_o
);

  // Sources: accelerators 0..NumAcc-1, error buffer is source NumAcc.
  localparam int unsigned NumSrc  = NumAcc + 1;
  localparam int unsigned RrWidth = $clog2(NumSrc);
  localparam logic [RrWidth:0]   NumSrcW = (RrWidth+1)'(NumSrc);
  localparam logic [RrWidth-1:0] ErrSrc  = RrWidth'(NumAcc);

  logic                 err_valid_q, err_valid_d;
  logic [IdWidth-1:0]   err_id_q, err_id_d;
  logic [RrWidth-1:0]   rr_q, rr_d;
  logic                 p_valid_q, p_valid_d;
  logic [DataWidth-1:0] p_data0_q, p_data0_d, p_data1_q, p_data1_d;
  logic                 p_dual_q, p_dual_d, p_error_q, p_error_d;
  logic [IdWidth-1:0]   p_id_q, p_id_d;

  logic                 sel_mapped;
  logic                 err_accept;
  logic [NumSrc-1:0]    src_valid;
  logic                 grant_any;
  logic [RrWidth-1:0]   grant_idx;
  logic                 out_free;
  logic                 handshake;
  logic                 err_pop;

  // Payload is broadcast; only the valid is steered.
  assign m_q_addr_o      = {NumAcc{s_q_addr_i}};
  assign m_q_data_op_o   = {NumAcc{s_q_data_op_i}};
  assign m_q_data_arga_o = {NumAcc{s_q_data_arga_i}};
  assign m_q_data_argb_o = {NumAcc{s_q_data_argb_i}};
  assign m_q_data_argc_o = {NumAcc{s_q_data_argc_i}};
  assign m_q_id_o        = {NumAcc{s_q_id_i}};

  assign sel_mapped = (32'(s_q_addr_i) < NumAcc);

  // Request steering; all handshake signals held low while in reset.
  always_comb begin
    m_q_valid_o = '0;
    s_q_ready_o = 1'b0;
    if (rst_ni) begin
      if (sel_mapped) begin
        for (int k = 0; k < int'(NumAcc); k++) begin
          if (s_q_addr_i == AddrWidth'(k)) begin
            m_q_valid_o[k] = s_q_valid_i;
            s_q_ready_o    = m_q_ready_i[k];
          end
        end
      end else begin
        s_q_ready_o = !err_valid_q;
      end
    end
  end

  assign err_accept = s_q_valid_i && s_q_ready_o && !sel_mapped;
  assign src_valid  = {err_valid_q, m_p_valid_i};

  // Round-robin pick: first valid source at or after rr, wrapping.
  always_comb begin
    logic [RrWidth:0] cand;
    cand      = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < int'(NumSrc); i++) begin
      cand = {1'b0, rr_q} + (RrWidth+1)'(i);
      if (cand >= NumSrcW) cand = cand - NumSrcW;
      if (!grant_any && src_valid[cand[RrWidth-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[RrWidth-1:0];
      end
    end
  end

  assign out_free  = !p_valid_q || s_p_ready_i;
  assign handshake = rst_ni && grant_any && out_free;
  assign err_pop   = handshake && (grant_idx == ErrSrc);

  // Pop the granted accelerator when the output register can take it.
  always_comb begin
    m_p_ready_o = '0;
    for (int k = 0; k < int'(NumAcc); k++) begin
      m_p_ready_o[k] = handshake && (grant_idx == RrWidth'(k));
    end
  end

  // Next state for the output register, pointer and error buffer.
  always_comb begin
    p_valid_d   = p_valid_q;
    p_data0_d   = p_data0_q;
    p_data1_d   = p_data1_q;
    p_dual_d    = p_dual_q;
    p_error_d   = p_error_q;
    p_id_d      = p_id_q;
    rr_d        = rr_q;
    err_valid_d = err_valid_q;
    err_id_d    = err_id_q;
    if (handshake) begin
      p_valid_d = 1'b1;
      rr_d      = (grant_idx == ErrSrc) ? '0 : grant_idx + RrWidth'(1);
      if (grant_idx == ErrSrc) begin
        p_data0_d = '0;
        p_data1_d = '0;
        p_dual_d  = 1'b0;
        p_error_d = 1'b1;
        p_id_d    = err_id_q;
      end else begin
        for (int k = 0; k < int'(NumAcc); k++) begin
          if (grant_idx == RrWidth'(k)) begin
            p_data0_d = m_p_data0_i[k*DataWidth +: DataWidth];
            p_data1_d = m_p_data1_i[k*DataWidth +: DataWidth];
            p_dual_d  = m_p_dual_writeback_i[k];
            p_error_d = m_p_error_i[k];
            p_id_d    = m_p_id_i[k*IdWidth +: IdWidth];
          end
        end
      end
    end else if (s_p_ready_i) begin
      p_valid_d = 1'b0;
    end
    if (err_pop)    err_valid_d = 1'b0;
    if (err_accept) begin
      err_valid_d = 1'b1;
      err_id_d    = s_q_id_i;
    end
  end

  // State registers with asynchronous reset dropping all buffered responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_valid_q   <= 1'b0;
      p_data0_q   <= '0;
      p_data1_q   <= '0;
      p_dual_q    <= 1'b0;
      p_error_q   <= 1'b0;
      p_id_q      <= '0;
      rr_q        <= '0;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
    end else begin
      p_valid_q   <= p_valid_d;
      p_data0_q   <= p_data0_d;
      p_data1_q   <= p_data1_d;
      p_dual_q    <= p_dual_d;
      p_error_q   <= p_error_d;
      p_id_q      <= p_id_d;
      rr_q        <= rr_d;
      err_valid_q <= err_valid_d;
      err_id_q    <= err_id_d;
    end
  end

  assign s_p_valid_o          = p_valid_q;
  assign s_p_data0_o          = p_data0_q;
  assign s_p_data1_o          = p_data1_q;
  assign s_p_dual_writeback_o = p_dual_q;
  assign s_p_error_o          = p_error_q;
  assign s_p_id_o             = p_id_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_demux
// Purpose  : Directed self-checking bench for acc_demux (NumAcc = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_demux;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int IW = 5;
  localparam int NA = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [AW-1:0]     s_q_addr_i;
  logic [31:0]       s_q_data_op_i;
  logic [DW-1:0]     s_q_data_arga_i, s_q_data_argb_i, s_q_data_argc_i;
  logic [IW-1:0]     s_q_id_i;
  logic              s_q_valid_i;
  logic              s_q_ready_o;
  logic [DW-1:0]     s_p_data0_o, s_p_data1_o;
  logic              s_p_dual_writeback_o, s_p_error_o;
  logic [IW-1:0]     s_p_id_o;
  logic              s_p_valid_o;
  logic              s_p_ready_i;
  logic [NA*AW-1:0]  m_q_addr_o;
  logic [NA*32-1:0]  m_q_data_op_o;
  logic [NA*DW-1:0]  m_q_data_arga_o, m_q_data_argb_o, m_q_data_argc_o;
  logic [NA*IW-1:0]  m_q_id_o;
  logic [NA-1:0]     m_q_valid_o;
  logic [NA-1:0]     m_q_ready_i;
  logic [NA*DW-1:0]  m_p_data0_i, m_p_data1_i;
  logic [NA-1:0]     m_p_dual_writeback_i, m_p_error_i;
  logic [NA*IW-1:0]  m_p_id_i;
  logic [NA-1:0]     m_p_valid_i;
  logic [NA-1:0]     m_p_ready_o;

  int n_checks = 0;
  int n_errors = 0;
  int hs;
  int hs_cyc;
  logic [IW-1:0] exp_id;

  acc_demux #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW), .NumAcc(NA)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_q_addr_i(s_q_addr_i), .s_q_data_op_i(s_q_data_op_i),
    .s_q_data_arga_i(s_q_data_arga_i), .s_q_data_argb_i(s_q_data_argb_i),
    .s_q_data_argc_i(s_q_data_argc_i), .s_q_id_i(s_q_id_i),
    .s_q_valid_i(s_q_valid_i), .s_q_ready_o(s_q_ready_o),
    .s_p_data0_o(s_p_data0_o), .s_p_data1_o(s_p_data1_o),
    .s_p_dual_writeback_o(s_p_dual_writeback_o), .s_p_error_o(s_p_error_o),
    .s_p_id_o(s_p_id_o), .s_p_valid_o(s_p_valid_o), .s_p_ready_i(s_p_ready_i),
    .m_q_addr_o(m_q_addr_o), .m_q_data_op_o(m_q_data_op_o),
    .m_q_data_arga_o(m_q_data_arga_o), .m_q_data_argb_o(m_q_data_argb_o),
    .m_q_data_argc_o(m_q_data_argc_o), .m_q_id_o(m_q_id_o),
    .m_q_valid_o(m_q_valid_o), .m_q_ready_i(m_q_ready_i),
    .m_p_data0_i(m_p_data0_i), .m_p_data1_i(m_p_data1_i),
    .m_p_dual_writeback_i(m_p_dual_writeback_i), .m_p_error_i(m_p_error_i),
    .m_p_id_i(m_p_id_i), .m_p_valid_i(m_p_valid_i), .m_p_ready_o(m_p_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    s_q_addr_i = 4'd2; s_q_data_op_i = '0; s_q_data_arga_i = '0;
    s_q_data_argb_i = '0; s_q_data_argc_i = '0; s_q_id_i = '0;
    s_q_valid_i = 1'b1; s_p_ready_i = 1'b1; m_q_ready_i = 4'b1111;
    m_p_data0_i = '0; m_p_data1_i = '0; m_p_dual_writeback_i = '0;
    m_p_error_i = '0; m_p_id_i = '0; m_p_valid_i = 4'b1111;

    // Reset state: handshakes forced low, response register cleared.
    tick(); tick();
    chk("rst_p_valid", s_p_valid_o, 0);
    chk("rst_p_data0", s_p_data0_o, 0);
    chk("rst_q_ready", s_q_ready_o, 0);
    chk("rst_m_q_valid", m_q_valid_o, 0);
    chk("rst_m_p_ready", m_p_ready_o, 0);
    s_q_valid_i = 1'b0; m_p_valid_i = '0; m_q_ready_i = '0;
    rst_ni = 1'b1;
    tick();

    // Routing to accelerator 2 with broadcast payload.
    s_q_addr_i = 4'd2; s_q_id_i = 5'd5; s_q_data_op_i = 32'h0000_0033;
    s_q_data_arga_i = 32'hAAAA_0001; s_q_valid_i = 1'b1; m_q_ready_i = 4'b0100;
    #1;
    chk("route_m_q_valid", m_q_valid_o, 4'b0100);
    chk("route_op2", m_q_data_op_o[2*32 +: 32], 32'h33);
    chk("route_id2", m_q_id_o[2*IW +: IW], 5);
    chk("route_arga0", m_q_data_arga_o[0 +: DW], 32'hAAAA_0001);
    chk("route_q_ready", s_q_ready_o, 1);
    tick();

    // Backpressure on accelerator 1 for three cycles.
    s_q_addr_i = 4'd1; hs = 0; hs_cyc = 0;
    for (int c = 1; c <= 4; c++) begin
      m_q_ready_i = (c == 4) ? 4'b0010 : 4'b0000;
      #1;
      chk("bp_m_q_valid", m_q_valid_o, 4'b0010);
      chk("bp_q_ready", s_q_ready_o, (c == 4) ? 1 : 0);
      if (s_q_valid_i && s_q_ready_o) begin
        hs++;
        hs_cyc = c;
      end
      tick();
    end
    chk("bp_hs_count", hs, 1);
    chk("bp_hs_cycle", hs_cyc, 4);
    s_q_valid_i = 1'b0; m_q_ready_i = '0;

    // Unmapped request: error response two cycles later, second one stalls.
    s_q_addr_i = 4'd7; s_q_id_i = 5'd9; s_q_valid_i = 1'b1;
    #1;
    chk("unm_q_ready", s_q_ready_o, 1);
    chk("unm_m_q_valid", m_q_valid_o, 0);
    tick();                                   // t+1
    chk("unm_t1_p_valid", s_p_valid_o, 0);
    s_q_addr_i = 4'd6; s_q_id_i = 5'd10;
    #1;
    chk("unm_second_stall", s_q_ready_o, 0);
    tick();                                   // t+2
    chk("unm_p_valid", s_p_valid_o, 1);
    chk("unm_p_error", s_p_error_o, 1);
    chk("unm_p_id", s_p_id_o, 9);
    chk("unm_p_data0", s_p_data0_o, 0);
    chk("unm_p_data1", s_p_data1_o, 0);
    chk("unm_p_dual", s_p_dual_writeback_o, 0);
    chk("unm_second_ready", s_q_ready_o, 1);
    tick();                                   // second accepted
    s_q_valid_i = 1'b0;
    chk("unm_t3_p_valid", s_p_valid_o, 0);
    tick();
    chk("unm2_p_valid", s_p_valid_o, 1);
    chk("unm2_p_id", s_p_id_o, 10);
    tick();
    chk("idle_p_valid", s_p_valid_o, 0);

    // Round robin over four accelerators plus a pending error.
    m_p_id_i    = {5'd3, 5'd2, 5'd1, 5'd0};
    m_p_data0_i = {32'h103, 32'h102, 32'h101, 32'h100};
    m_p_data1_i = {32'h203, 32'h202, 32'h201, 32'h200};
    m_p_dual_writeback_i = 4'b0010;
    m_p_valid_i = 4'b1111;
    s_q_addr_i = 4'd7; s_q_id_i = 5'd21; s_q_valid_i = 1'b1;
    #1;
    chk("rr_first_ready", m_p_ready_o, 4'b0001);
    chk("rr_err_accept", s_q_ready_o, 1);
    tick();
    s_q_valid_i = 1'b0;
    for (int j = 0; j < 6; j++) begin
      exp_id = (j == 4) ? 5'd21 : (j == 5) ? 5'd0 : 5'(j);
      chk("rr_p_valid", s_p_valid_o, 1);
      chk("rr_p_id", s_p_id_o, exp_id);
      chk("rr_p_error", s_p_error_o, (j == 4) ? 1 : 0);
      chk("rr_p_data0", s_p_data0_o, (j == 4) ? 0 : 32'h100 + exp_id);
      if (j < 5) tick();
    end

    // Upstream stall: everything holds, no accelerator is popped.
    s_p_ready_i = 1'b0;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("stall_m_p_ready", m_p_ready_o, 0);
      chk("stall_p_valid", s_p_valid_o, 1);
      chk("stall_p_id", s_p_id_o, 0);
      chk("stall_p_data1", s_p_data1_o, 32'h200);
      tick();
    end
    s_p_ready_i = 1'b1;
    #1;
    chk("release_m_p_ready", m_p_ready_o, 4'b0010);
    tick();
    chk("release_p_id", s_p_id_o, 1);
    chk("release_p_data0", s_p_data0_o, 32'h101);
    chk("release_p_dual", s_p_dual_writeback_o, 1);

    // Reset mid-flight with a held response and a pending error.
    m_p_valid_i = '0; s_p_ready_i = 1'b0;
    s_q_addr_i = 4'd7; s_q_id_i = 5'd3; s_q_valid_i = 1'b1;
    #1;
    chk("mf_err_accept", s_q_ready_o, 1);
    tick();
    s_q_valid_i = 1'b0;
    #1;
    chk("mf_err_pending", s_q_ready_o, 0);
    chk("mf_p_valid", s_p_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mf_rst_p_valid", s_p_valid_o, 0);
    chk("mf_rst_p_id", s_p_id_o, 0);
    chk("mf_rst_p_data0", s_p_data0_o, 0);
    tick();
    rst_ni = 1'b1;
    #1;
    chk("mf_err_cleared", s_q_ready_o, 1);
    m_p_valid_i = 4'b1111; s_p_ready_i = 1'b1;
    #1;
    chk("mf_rr_reset", m_p_ready_o, 4'b0001);
    tick();
    chk("mf_first_id", s_p_id_o, 0);
    chk("mf_first_valid", s_p_valid_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
